// File: rtl/latency_var.sv
// Multi-channel delay line with runtime-selectable latency, valid tracking and stall.
// Optional macro LATENCY_ZERO_EN allows latency 0 (combinational bypass of d to q).
module latency_var #(
  parameter  int MAX_LAT = 16,
  parameter  int DSIZE   = 8,
  parameter  int CH      = 3,
  parameter  int DEF_LAT = 2,
  localparam int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [LW-1:0]       lat_sel,
  input  logic                lat_load,
  input  logic [CH*DSIZE-1:0] d,
  input  logic                d_vld,
  output logic [CH*DSIZE-1:0] q,
  output logic                q_vld,
  output logic [LW-1:0]       cur_lat
);

  localparam int DW = CH * DSIZE;

  logic [DW-1:0] r_s [MAX_LAT];
  logic          r_v [MAX_LAT];
  logic [LW-1:0] r_cur;

  function automatic logic [LW-1:0] f_clamp(input logic [LW-1:0] x);
    if (x > LW'(MAX_LAT)) return LW'(MAX_LAT);
`ifndef LATENCY_ZERO_EN
    if (x == '0) return LW'(1);
`endif
    return x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_LAT; i++) begin
        r_s[i] <= '0;
        r_v[i] <= 1'b0;
      end
      r_cur <= LW'(DEF_LAT);
    end else begin
      if (en) begin
        r_s[0] <= d;
        r_v[0] <= d_vld;
        for (int unsigned i = 1; i < MAX_LAT; i++) begin
          r_s[i] <= r_s[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
      // Flush overrides the shift on valid bits only; a sample captured on the load edge survives.
      if (lat_load) begin
        r_cur <= f_clamp(lat_sel);
        for (int unsigned i = 1; i < MAX_LAT; i++) r_v[i] <= 1'b0;
        if (!en) r_v[0] <= 1'b0;
      end
    end
  end

  always_comb begin
    q     = '0;
    q_vld = 1'b0;
    for (int unsigned i = 0; i < MAX_LAT; i++) begin
      if (r_cur == LW'(i + 1)) begin
        q     = r_s[i];
        q_vld = r_v[i];
      end
    end
`ifdef LATENCY_ZERO_EN
    if (r_cur == '0) begin
      q     = d;
      q_vld = d_vld & en;
    end
`endif
  end

  assign cur_lat = r_cur;

endmodule
